ex_stage: RTL
=============

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have a single clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 stall  in  1  hold the EX/MEM register contents.
REQ-005 flush  in  1  load a bubble into the EX/MEM register.
REQ-006 valid_in  in  1  the ID/EX slot holds a real instruction.
REQ-007 pc_in, rd1_in, rd2_in, immext_in  in  32 each  operands from ID/EX.
REQ-008 rs1_in, rs2_in, rd_in  in  5 each  register indices from ID/EX.
REQ-009 alucontrol_in  in  3  ALU operation.
REQ-010 alusrc_in  in  1  B operand select: 0 = forwarded rd2, 1 = immext.
REQ-011 regwrite_in, memwrite_in  in  1 each  write controls.
REQ-012 resultsrc_in  in  2  result select; 01 = load.
REQ-013 result_w  in  32  writeback-stage result.
REQ-014 rd_w  in  5  writeback-stage destination.
REQ-015 regwrite_w  in  1  writeback-stage write enable.
REQ-016 aluresult_m, writedata_m, pcplus4_m  out  32 each  registered EX/MEM outputs.
REQ-017 rd_m  out  5  registered destination index.
REQ-018 regwrite_m, memwrite_m, valid_m  out  1 each  registered controls.
REQ-019 resultsrc_m  out  2  registered result select.
REQ-020 instr_count  out  32  count of instructions retired into MEM.

Function
REQ-021 SHALL define the forwarded A operand as aluresult_m when regwrite_m=1, resultsrc_m!=01, rd_m!=0 and rd_m==rs1_in.
REQ-022 SHALL otherwise define A as result_w when regwrite_w=1, rd_w!=0 and rd_w==rs1_in; otherwise A = rd1_in.
REQ-023 SHALL apply the REQ-021/022 rules to rs2_in/rd2_in to form fwdB; MEM-stage forwarding takes priority over WB-stage forwarding.
REQ-024 SHALL select B = immext_in when alusrc_in=1, else B = fwdB.
REQ-025 SHALL decode alucontrol: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 signed slt (result 1 or 0), 110 sll by B[4:0], 111 srl (logical) by B[4:0].
REQ-026 SHALL compute add and sub modulo 2^32, with no overflow flag.
REQ-027 SHALL compute pcplus4 as pc_in+4 modulo 2^32.
REQ-028 SHALL, on a rising edge with flush=1, load a bubble: valid_m=0, regwrite_m=0, memwrite_m=0; the data fields are don't-care, but the implementation drives them to 0.
REQ-029 SHALL, on a rising edge with flush=0 and stall=1, hold all EX/MEM outputs; flush has priority over stall.
REQ-030 SHALL otherwise capture aluresult, fwdB (as writedata), pcplus4, rd_in, resultsrc_in and valid_in.
REQ-031 SHALL, in the capture case of REQ-030, gate regwrite_m and memwrite_m with valid_in.
REQ-032 SHALL have a latency of exactly 1 cycle from the ID/EX inputs to the EX/MEM outputs.
REQ-033 SHALL increment instr_count by 1 on each edge that captures valid_in=1 per REQ-030.
REQ-034 SHALL wrap instr_count from FFFFFFFF to 0.
REQ-035 SHALL never forward register x0; a read of x0 uses rd1_in or rd2_in unchanged.

Reset
REQ-036 SHALL, while reset=0 and immediately without waiting for clk, drive all EX/MEM outputs and instr_count to 0.
REQ-037 SHALL, when reset asserts mid-operation, discard the in-flight instruction and leave no partial count.
REQ-038 SHALL perform its first capture on the first rising edge after reset deasserts.

Verification
REQ-039 Scenario, add with imm: rd1=5, imm=7, alusrc=1, alucontrol=000, rd=3, valid=1 -> next edge: aluresult_m=12, rd_m=3, valid_m=1, instr_count=1.
REQ-040 Scenario, forwarding priority: rs1=4, rd_m=4 (regwrite_m=1, resultsrc_m=00, aluresult_m=AA), rd_w=4 (result_w=BB), alucontrol=000, B=0 -> aluresult=AA; repeat with resultsrc_m=01 -> BB.
REQ-041 Scenario, slt and shifts: A=FFFFFFFF, B=1, alucontrol=101 -> 1; A=80000000, B=0x21, alucontrol=111 -> 40000000.
REQ-042 Scenario, stall+flush: stall=1 holds outputs across 3 edges with instr_count unchanged; stall=1 with flush=1 -> valid_m=0, regwrite_m=0, memwrite_m=0.
REQ-043 Scenario, async reset: drive reset=0 between edges -> all outputs 0 before the next clk edge; release, first valid capture -> instr_count=1.
REQ-044 Scenario, counter wrap: preload instr_count to FFFFFFFF via repeated captures or force -> next valid capture gives 0.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, and the EX/MEM pipeline register
// with a count of instructions retired into MEM.
module ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        valid_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] rd1_in,
    input  logic [31:0] rd2_in,
    input  logic [31:0] immext_in,
    input  logic [4:0]  rs1_in,
    input  logic [4:0]  rs2_in,
    input  logic [4:0]  rd_in,
    input  logic [2:0]  alucontrol_in,
    input  logic        alusrc_in,
    input  logic        regwrite_in,
    input  logic        memwrite_in,
    input  logic [1:0]  resultsrc_in,
    input  logic [31:0] result_w,
    input  logic [4:0]  rd_w,
    input  logic        regwrite_w,
    output logic [31:0] aluresult_m,
    output logic [31:0] writedata_m,
    output logic [31:0] pcplus4_m,
    output logic [4:0]  rd_m,
    output logic        regwrite_m,
    output logic        memwrite_m,
    output logic        valid_m,
    output logic [1:0]  resultsrc_m,
    output logic [31:0] instr_count
);

    logic [31:0] src_a;
    logic [31:0] fwd_b;
    logic [31:0] src_b;
    logic [31:0] alu_y;
    logic [31:0] count_q;
    logic        mem_fwd_ok;

    // A load in MEM has no data yet, so it must not be forwarded from MEM.
    assign mem_fwd_ok = regwrite_m && (resultsrc_m != 2'b01) && (rd_m != 5'd0);

    always_comb begin
        src_a = rd1_in;
        if (mem_fwd_ok && (rd_m == rs1_in))
            src_a = aluresult_m;
        else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs1_in))
            src_a = result_w;

        fwd_b = rd2_in;
        if (mem_fwd_ok && (rd_m == rs2_in))
            fwd_b = aluresult_m;
        else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs2_in))
            fwd_b = result_w;

        src_b = alusrc_in ? immext_in : fwd_b;
    end

    always_comb begin
        alu_y = '0;
        unique case (alucontrol_in)
            3'b000: alu_y = src_a + src_b;
            3'b001: alu_y = src_a - src_b;
            3'b010: alu_y = src_a & src_b;
            3'b011: alu_y = src_a | src_b;
            3'b100: alu_y = src_a ^ src_b;
            3'b101: alu_y = {31'd0, $signed(src_a) < $signed(src_b)};
            3'b110: alu_y = src_a << src_b[4:0];
            3'b111: alu_y = src_a >> src_b[4:0];
            default: alu_y = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aluresult_m <= '0;
            writedata_m <= '0;
            pcplus4_m   <= '0;
            rd_m        <= '0;
            regwrite_m  <= 1'b0;
            memwrite_m  <= 1'b0;
            valid_m     <= 1'b0;
            resultsrc_m <= '0;
            count_q     <= '0;
        end else if (flush) begin
            aluresult_m <= '0;
            writedata_m <= '0;
            pcplus4_m   <= '0;
            rd_m        <= '0;
            regwrite_m  <= 1'b0;
            memwrite_m  <= 1'b0;
            valid_m     <= 1'b0;
            resultsrc_m <= '0;
        end else if (!stall) begin
            aluresult_m <= alu_y;
            writedata_m <= fwd_b;
            pcplus4_m   <= pc_in + 32'd4;
            rd_m        <= rd_in;
            regwrite_m  <= regwrite_in && valid_in;
            memwrite_m  <= memwrite_in && valid_in;
            valid_m     <= valid_in;
            resultsrc_m <= resultsrc_in;
            if (valid_in)
                count_q <= count_q + 32'd1;
        end
    end

    assign instr_count = count_q;

endmodule
